// File: rtl/serial_adder_fsm.sv
// Bit-serial adder: S = A + B + Cin, one bit per clock, built around a minterm full adder.
// Optional signed-overflow output V is enabled by defining SERIAL_ADD_OVF_EN.

module serial_adder_fa (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    logic [7:0] m;

    // m[k] is high when {a,b,c} equals minterm k
    for (genvar k = 0; k < 8; k++) begin : g_mt
        assign m[k] = ({a_i, b_i, c_i} == 3'(k));
    end

    assign s_o  = m[1] | m[2] | m[4] | m[7];
    assign co_o = m[3] | m[5] | m[6] | m[7];
endmodule

module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] s_o,
    output logic             cout_o
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             v_o
`endif
);
    localparam int NW = $clog2(WIDTH + 1);
    localparam logic [NW-1:0] N_LAST = NW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] ra_q, rb_q, s_q;
    logic             c_q, cout_q, busy_q, done_q;
    logic [NW-1:0]    n_q;
    logic [WIDTH-1:0] ra_d, rb_d, s_d;
    logic             fa_s, fa_c;

    serial_adder_fa u_fa (
        .a_i  (ra_q[0]),
        .b_i  (rb_q[0]),
        .c_i  (c_q),
        .s_o  (fa_s),
        .co_o (fa_c)
    );

    assign ra_d = {1'b0, ra_q[WIDTH-1:1]};
    assign rb_d = {1'b0, rb_q[WIDTH-1:1]};
    assign s_d  = {fa_s, s_q[WIDTH-1:1]};

`ifdef SERIAL_ADD_OVF_EN
    localparam logic [NW-1:0] N_PEN = NW'(WIDTH - 2);
    logic cmsb_q, v_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            c_q     <= 1'b0;
            n_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            cmsb_q  <= 1'b0;
            v_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        ra_q    <= a_i;
                        rb_q    <= b_i;
                        c_q     <= cin_i;
                        n_q     <= '0;
                        s_q     <= '0;
                        busy_q  <= 1'b1;
                        state_q <= SHIFT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                SHIFT: begin
                    ra_q <= ra_d;
                    rb_q <= rb_d;
                    s_q  <= s_d;
                    c_q  <= fa_c;
                    n_q  <= n_q + 1'b1;
`ifdef SERIAL_ADD_OVF_EN
                    // carry into the sign bit, needed for the overflow flag
                    if (n_q == N_PEN) cmsb_q <= fa_c;
`endif
                    if (n_q == N_LAST) begin
                        cout_q  <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                        v_q     <= cmsb_q ^ fa_c;
`endif
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign s_o    = s_q;
    assign cout_o = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    assign v_o    = v_q;
`endif
endmodule

// File: tb/tb_serial_adder_fsm.sv
// Randomized + directed bench for serial_adder_fsm against an arithmetic reference model.
// Checks V only when SERIAL_ADD_OVF_EN is defined.

module tb_serial_adder_fsm;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] s;
`ifdef SERIAL_ADD_OVF_EN
    logic         v;
`endif

    int nvec = 0;
    int nerr = 0;

    serial_adder_fsm #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
        .busy_o  (busy),
        .done_o  (done),
        .s_o     (s),
        .cout_o  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .v_o     (v)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // reference: plain integer arithmetic
    function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        int sx, sy, t;
        sx = x[W-1] ? int'(x) - (1 << W) : int'(x);
        sy = y[W-1] ? int'(y) - (1 << W) : int'(y);
        t  = sx + sy + int'(ci);
        return (t > (1 << (W-1)) - 1) || (t < -(1 << (W-1)));
    endfunction

    task automatic chk_result(input string tag, input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
        logic [W:0] r;
        r = ref_sum(x, y, ci);
        chk({tag, "_S"}, 32'(s), 32'(r[W-1:0]));
        chk({tag, "_Cout"}, 32'(cout), 32'(r[W]));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_V"}, 32'(v), 32'(ref_ovf(x, y, ci)));
`endif
    endtask

    // Called #1 after an edge with busy=0; glitch>0 pulses start with zero operands mid-op.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input int glitch);
        start = 1'b1; a = x; b = y; cin = ci;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom()); b = W'($urandom()); cin = 1'($urandom());
        chk({tag, "_busy_t0"}, 32'(busy), 32'd1);
        for (int k = 1; k < W; k++) begin
            @(posedge clk); #1;
            chk({tag, "_busy"}, 32'(busy), 32'd1);
            chk({tag, "_nodone"}, 32'(done), 32'd0);
            start = (k == glitch);
            if (k == glitch) begin a = '0; b = '0; end
        end
        start = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
        chk_result(tag, x, y, ci);
        @(posedge clk); #1;
        chk({tag, "_donefall"}, 32'(done), 32'd0);
        chk_result({tag, "_hold"}, x, y, ci);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_S", 32'(s), 32'd0);
        chk("rst_Cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("rst_V", 32'(v), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("3c5a", 8'h3C, 8'h5A, 1'b0, 0);
        run_op("ff01", 8'hFF, 8'h01, 1'b0, 0);
        run_op("ffff", 8'hFF, 8'hFF, 1'b1, 0);
        run_op("7f01", 8'h7F, 8'h01, 1'b0, 0);
        run_op("ignst", 8'h10, 8'h20, 1'b0, 3);

        // reset in the middle of an operation
        start = 1'b1; a = 8'hAB; b = 8'hCD; cin = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_S", 32'(s), 32'd0);
        chk("mrst_Cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADD_OVF_EN
        chk("mrst_V", 32'(v), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst", 8'h01, 8'h01, 1'b0, 0);

        // start held high: one result every W+1 cycles
        start = 1'b1; a = 8'h0F; b = 8'h01; cin = 1'b0;
        @(posedge clk); #1;
        chk("b2b_busy_t0", 32'(busy), 32'd1);
        for (int r = 0; r < 4; r++) begin
            repeat (W - 1) begin
                @(posedge clk); #1;
                chk("b2b_busy", 32'(busy), 32'd1);
                chk("b2b_nodone", 32'(done), 32'd0);
            end
            @(posedge clk); #1;
            chk("b2b_done", 32'(done), 32'd1);
            chk("b2b_idle", 32'(busy), 32'd0);
            chk_result("b2b", 8'h0F, 8'h01, 1'b0);
            @(posedge clk); #1;
            chk("b2b_restart", 32'(busy), 32'd1);
            chk("b2b_donefall", 32'(done), 32'd0);
        end
        start = 1'b0;
        repeat (W) @(posedge clk);
        #1;

        for (int i = 0; i < 40; i++) begin
            run_op("rnd", W'($urandom()), W'($urandom()), 1'($urandom()), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
